// File: rtl/isp_conv_mask_gen_pkg.sv
// ---------------------------------------------------------------------------
// isp_conv_pkg
// Shared definitions for the 5x5 demosaic convolution engine:
//   - mask select encodings (mode_e)
//   - 2x-scaled signed tap weights and the coefficient-set layout
//   - rounding constants (result = (sum + RND) >>> SHIFT)
//   - helpers splitting a signed weight into sign and magnitude
// ---------------------------------------------------------------------------
package isp_conv_pkg;

    localparam int SHIFT  = 4;
    localparam int RND    = 8;
    localparam int COEF_W = 6;   // signed weight width, holds -16..+16 range needed
    localparam int MAG_W  = 5;   // weight magnitude width, up to 16

    typedef enum logic [2:0] {
        MODE_BYPASS   = 3'd0,
        MODE_G_AT_RB  = 3'd1,
        MODE_RB_G_ROW = 3'd2,
        MODE_RB_G_COL = 3'd3,
        MODE_RB_AT_BR = 3'd4
    } mode_e;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t K_0   = 6'sd0;
    localparam coef_t K_P1  = 6'sd1;
    localparam coef_t K_M2  = -6'sd2;
    localparam coef_t K_M3  = -6'sd3;
    localparam coef_t K_P4  = 6'sd4;
    localparam coef_t K_P8  = 6'sd8;
    localparam coef_t K_P10 = 6'sd10;
    localparam coef_t K_P12 = 6'sd12;
    localparam coef_t K_P16 = 6'sd16;

    // Tap order inside each group matches the pixel packing: index 0 in LSBs
    // ax1 {E,W,S,N}, diag {SE,SW,NE,NW}, ax2 {EE,WW,SS,NN}
    typedef struct packed {
        coef_t       c;
        coef_t [3:0] ax1;
        coef_t [3:0] diag;
        coef_t [3:0] ax2;
    } coef_set_t;

    function automatic logic coef_neg(input coef_t w);
        return w[COEF_W-1];
    endfunction

    function automatic logic [MAG_W-1:0] coef_mag(input coef_t w);
        coef_t t;
        t = w[COEF_W-1] ? -w : w;
        return t[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/isp_conv_mask_gen_if.sv
// ---------------------------------------------------------------------------
// isp_conv_mask_gen_if
// Pixel-set input and interpolated-pixel output of the convolution engine.
//   in_valid, mode, pix_c, pix_ax1, pix_diag, pix_ax2 : upstream -> engine
//   out_pix, out_valid                                : engine -> downstream
// master: window generator side; slave: the convolution engine.
// ---------------------------------------------------------------------------
interface isp_conv_mask_gen_if #(
    parameter int DW = 8
) ();
    logic            in_valid;
    logic [2:0]      mode;
    logic [DW-1:0]   pix_c;
    logic [4*DW-1:0] pix_ax1;
    logic [4*DW-1:0] pix_diag;
    logic [4*DW-1:0] pix_ax2;
    logic [DW-1:0]   out_pix;
    logic            out_valid;

    modport master (
        output in_valid, mode, pix_c, pix_ax1, pix_diag, pix_ax2,
        input  out_pix, out_valid
    );

    modport slave (
        input  in_valid, mode, pix_c, pix_ax1, pix_diag, pix_ax2,
        output out_pix, out_valid
    );
endinterface

// File: rtl/isp_conv_mask_coef.sv
// ---------------------------------------------------------------------------
// isp_conv_mask_coef
// Combinational mask select -> signed tap weights (2x scale, each mask sums
// to 16). Unknown modes fall back to bypass (centre weight 16 only).
//   i_mode : mask select
//   o_coef : weights for centre, ax1, diag and ax2 taps
// ---------------------------------------------------------------------------
module isp_conv_mask_coef
    import isp_conv_pkg::*;
(
    input  logic [2:0] i_mode,
    output coef_set_t  o_coef
);

    always_comb begin
        o_coef = '0;
        case (mode_e'(i_mode))
            MODE_G_AT_RB: begin
                o_coef.c    = K_P8;
                o_coef.ax1  = {4{K_P4}};
                o_coef.ax2  = {4{K_M2}};
            end
            MODE_RB_G_ROW: begin
                o_coef.c    = K_P10;
                o_coef.ax1  = {K_P8, K_P8, K_0, K_0};     // E,W,S,N
                o_coef.diag = {4{K_M2}};
                o_coef.ax2  = {K_M2, K_M2, K_P1, K_P1};   // EE,WW,SS,NN
            end
            MODE_RB_G_COL: begin
                o_coef.c    = K_P10;
                o_coef.ax1  = {K_0, K_0, K_P8, K_P8};
                o_coef.diag = {4{K_M2}};
                o_coef.ax2  = {K_P1, K_P1, K_M2, K_M2};
            end
            MODE_RB_AT_BR: begin
                o_coef.c    = K_P12;
                o_coef.diag = {4{K_P4}};
                o_coef.ax2  = {4{K_M3}};
            end
            default: begin
                o_coef.c    = K_P16;
            end
        endcase
    end

endmodule

// File: rtl/isp_conv_mask_gen.sv
// ---------------------------------------------------------------------------
// isp_conv_mask_gen
// Mode-selectable 5x5 demosaic convolution, 3-stage pipeline with clken stall.
//   S1: weight decode, per-tap products into per-group pos/neg partials
//   S2: total positive and negative sums
//   S3: subtract, round, clamp to 0..2^DW-1 into out_pix
// Ports:
//   clk, rst_n (async, active-low), clken (0 holds every stage)
//   bus (slave): in_valid/mode/pixels in, out_pix/out_valid out
// ---------------------------------------------------------------------------
module isp_conv_mask_gen
    import isp_conv_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clken,
    isp_conv_mask_gen_if.slave bus
);

    localparam int AW = DW + 5;   // unsigned accumulator width
    localparam int SW = DW + 6;   // signed difference width

    coef_set_t w_coef;

    isp_conv_mask_coef u_coef (
        .i_mode (bus.mode),
        .o_coef (w_coef)
    );

    function automatic logic [AW-1:0] tap_prod(input coef_t w, input logic [DW-1:0] p);
        return AW'(coef_mag(w)) * AW'(p);
    endfunction

    // Group index: 0 centre, 1 ax1, 2 diag, 3 ax2
    logic [AW-1:0] w_grp_pos [4];
    logic [AW-1:0] w_grp_neg [4];

    always_comb begin
        for (int unsigned g = 0; g < 4; g++) begin
            w_grp_pos[g] = '0;
            w_grp_neg[g] = '0;
        end
        if (coef_neg(w_coef.c)) w_grp_neg[0] = tap_prod(w_coef.c, bus.pix_c);
        else                    w_grp_pos[0] = tap_prod(w_coef.c, bus.pix_c);
        for (int unsigned i = 0; i < 4; i++) begin
            if (coef_neg(w_coef.ax1[i[1:0]]))
                w_grp_neg[1] = w_grp_neg[1] + tap_prod(w_coef.ax1[i[1:0]], bus.pix_ax1[i*DW +: DW]);
            else
                w_grp_pos[1] = w_grp_pos[1] + tap_prod(w_coef.ax1[i[1:0]], bus.pix_ax1[i*DW +: DW]);
            if (coef_neg(w_coef.diag[i[1:0]]))
                w_grp_neg[2] = w_grp_neg[2] + tap_prod(w_coef.diag[i[1:0]], bus.pix_diag[i*DW +: DW]);
            else
                w_grp_pos[2] = w_grp_pos[2] + tap_prod(w_coef.diag[i[1:0]], bus.pix_diag[i*DW +: DW]);
            if (coef_neg(w_coef.ax2[i[1:0]]))
                w_grp_neg[3] = w_grp_neg[3] + tap_prod(w_coef.ax2[i[1:0]], bus.pix_ax2[i*DW +: DW]);
            else
                w_grp_pos[3] = w_grp_pos[3] + tap_prod(w_coef.ax2[i[1:0]], bus.pix_ax2[i*DW +: DW]);
        end
    end

    logic [AW-1:0] r_s1_pos [4];
    logic [AW-1:0] r_s1_neg [4];
    logic          r_s1_valid;
    logic [AW-1:0] r_s2_pos;
    logic [AW-1:0] r_s2_neg;
    logic          r_s2_valid;
    logic [DW-1:0] r_out_pix;
    logic          r_out_valid;

    logic [AW-1:0] w_pos_sum;
    logic [AW-1:0] w_neg_sum;

    always_comb begin
        w_pos_sum = '0;
        w_neg_sum = '0;
        for (int unsigned g = 0; g < 4; g++) begin
            w_pos_sum = w_pos_sum + r_s1_pos[g];
            w_neg_sum = w_neg_sum + r_s1_neg[g];
        end
    end

    logic signed [SW-1:0] w_diff;
    logic signed [SW-1:0] w_rnd;
    logic signed [SW-1:0] w_shr;
    logic [DW-1:0]        w_sat;

    always_comb begin
        w_diff = $signed({1'b0, r_s2_pos}) - $signed({1'b0, r_s2_neg});
        w_rnd  = w_diff + SW'(RND);
        w_shr  = w_rnd >>> SHIFT;
        // Negative -> 0; any bit above DW set on a positive value -> full scale
        if (w_shr[SW-1])
            w_sat = '0;
        else if (|w_shr[SW-2:DW])
            w_sat = '1;
        else
            w_sat = w_shr[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_pos    <= '{default: '0};
            r_s1_neg    <= '{default: '0};
            r_s1_valid  <= 1'b0;
            r_s2_pos    <= '0;
            r_s2_neg    <= '0;
            r_s2_valid  <= 1'b0;
            r_out_pix   <= '0;
            r_out_valid <= 1'b0;
        end else if (clken) begin
            r_s1_pos    <= w_grp_pos;
            r_s1_neg    <= w_grp_neg;
            r_s1_valid  <= bus.in_valid;
            r_s2_pos    <= w_pos_sum;
            r_s2_neg    <= w_neg_sum;
            r_s2_valid  <= r_s1_valid;
            r_out_pix   <= w_sat;
            r_out_valid <= r_s2_valid;
        end
    end

    assign bus.out_pix   = r_out_pix;
    assign bus.out_valid = r_out_valid;

endmodule
